y86_pc_sequencer: RTL and testbench
===================================

# y86_pc_sequencer

- Owns the architectural PC and run control for the Y86 SEQ core, replacing the free-running PC register that currently updates on every clock.
- Sits between the `updatePC` output (`next_PC`) and the `fetch` input (`PC_i`). It adds the following, which the free-running register does not have:
  - parametrised reset vector and address width,
  - run/step/stop control,
  - status-driven stopping on HLT/ADR/INS,
  - N address breakpoints,
  - saturating cycle and retired-instruction counters.

## Interface
Parameters:
- ADDR_W, 64, PC width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 32, width of each performance counter.
- NUM_BP, 2, number of breakpoint comparators (1..8).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; one clock, asynchronous, active-low.
- next_pc_i  in  ADDR_W  next PC from updatePC.
- stat_i  in  4  status from write_back: AOK=1, HLT=2, ADR=3, INS=4.
- run_i  in  1  start free-running execution; level sampled per cycle.
- step_i  in  1  execute exactly one instruction.
- halt_req_i  in  1  request stop after the current instruction.
- bp_addr_i  in  NUM_BP*ADDR_W  breakpoint addresses; slot k occupies bits [k*ADDR_W +: ADDR_W].
- bp_en_i  in  NUM_BP  per-slot breakpoint enable.
- pc_o  out  ADDR_W  current PC, drives fetch.
- commit_o  out  1  the coming rising edge retires the instruction at pc_o (combinational).
- state_o  out  2  IDLE=0, RUN=1, STEP=2, STOP=3.
- stat_o  out  4  latched machine status.
- bp_hit_o  out  NUM_BP  sticky breakpoint-hit flags.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN or STEP.
- instr_cnt_o  out  CNT_W  retired instructions.

## Operation
Reset values (rst_i low): pc_o=RESET_PC, state_o=IDLE, stat_o=1 (AOK), bp_hit_o=0, cycle_cnt_o=0, instr_cnt_o=0. These apply immediately, with no clock needed. Asserting reset mid-RUN abandons the in-flight instruction.

commit_o is (state is RUN or STEP) AND stat_i==AOK.

On a commit edge:
- pc <= next_pc_i.
- instr_cnt += 1, saturating at all-ones.

Fault edge (state is RUN or STEP and stat_i != AOK):
- No commit; pc holds, so it points at the faulting or halting instruction.
- stat_o <= stat_i; state <= STOP.

cycle_cnt += 1, saturating, on every edge where state is RUN or STEP.

Breakpoint match: slot k matches when bp_en_i[k] and next_pc_i == slot k address. It is evaluated only on commit edges.

State transitions:
- IDLE:
  - step_i → STEP (step_i wins over run_i).
  - Else run_i → RUN.
  - Either transition clears bp_hit_o.
  - No commit on the entry edge.
- RUN:
  - Fault → STOP.
  - Else any breakpoint match → IDLE, and set the matching bp_hit_o bits. The commit still occurs, so pc_o equals the breakpoint address and that instruction has not yet executed.
  - Else halt_req_i → IDLE, after the commit.
  - Else stay in RUN.
- STEP:
  - Fault → STOP.
  - Else → IDLE after one commit. Breakpoint bits are still set on a match.
- STOP: terminal. Only reset leaves it. run_i, step_i and halt_req_i are ignored.

run_i, step_i and halt_req_i are ignored outside the states listed above.

## Timing
- Entering RUN from IDLE takes one edge. The first commit happens on the next edge, so pc_o changes 2 edges after run_i is sampled.
- STEP: sample edge enters STEP, the next edge commits, and state is IDLE after that edge. The total is 2 cycles per step.
- A fault is visible on stat_o and state_o one edge after stat_i goes non-AOK in RUN/STEP. pc_o never changes on a fault edge.
- A breakpoint and halt_req_i on the same edge both go to IDLE; bp_hit_o is set.
- A fault and a breakpoint on the same edge resolve to the fault: STOP, no bp_hit.
- Counters saturate and never wrap.
- All outputs except commit_o are registered.

## Test plan
- Reset with RESET_PC=0x100, then release → pc_o=0x100, state_o=0, stat_o=1, both counters 0. Holding next_pc_i without run_i leaves pc_o unchanged for 10 cycles.
- Pulse run_i with next_pc_i following pc+10 for 5 commits, then stat_i=2 → pc_o frozen at the HLT address, stat_o=2, state_o=3, instr_cnt_o=5, cycle_cnt_o=6. run_i and step_i are then ignored.
- bp_addr slot1=0x28 enabled, run from 0 with next PC = pc+10 → state_o=0 after the commit to 0x28, pc_o=0x28, bp_hit_o=2'b10, instr_cnt_o=4. A following step_i clears bp_hit_o and advances to 0x32.
- step_i and run_i asserted together in IDLE → exactly one commit, then IDLE; instr_cnt_o increments by 1.
- CNT_W=4 with 20 commits in RUN → instr_cnt_o holds at 15.
- Drop rst_i asynchronously mid-RUN (between edges) → outputs take reset values immediately. After release, state_o=0 until run_i is asserted.

Source files
------------

// File: rtl/y86_pc_sequencer.sv
// Architectural PC and run control for the Y86 SEQ core: run/step/stop, status stop, breakpoints, counters.
// All outputs registered except commit_o, which flags that the coming edge retires the instruction at pc_o.
module y86_pc_sequencer #(
    parameter int                 ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 32,
    parameter int                 NUM_BP   = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ADDR_W-1:0]          next_pc_i,
    input  logic [3:0]                 stat_i,
    input  logic                       run_i,
    input  logic                       step_i,
    input  logic                       halt_req_i,
    input  logic [NUM_BP*ADDR_W-1:0]   bp_addr_i,
    input  logic [NUM_BP-1:0]          bp_en_i,
    output logic [ADDR_W-1:0]          pc_o,
    output logic                       commit_o,
    output logic [1:0]                 state_o,
    output logic [3:0]                 stat_o,
    output logic [NUM_BP-1:0]          bp_hit_o,
    output logic [CNT_W-1:0]           cycle_cnt_o,
    output logic [CNT_W-1:0]           instr_cnt_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    localparam logic [3:0] STAT_AOK = 4'd1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [3:0]          stat_q, stat_d;
    logic [NUM_BP-1:0]   bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    instr_q, instr_d;
    logic [NUM_BP-1:0]   bp_match;
    logic                active;
    logic                commit;
    logic                fault;

    assign active = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign commit = active && (stat_i == STAT_AOK);
    assign fault  = active && (stat_i != STAT_AOK);

    always_comb begin
        bp_match = '0;
        for (int k = 0; k < NUM_BP; k++) begin
            bp_match[k] = bp_en_i[k] && (next_pc_i == bp_addr_i[k*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        stat_d   = stat_q;
        bp_hit_d = bp_hit_q;
        cycle_d  = cycle_q;
        instr_d  = instr_q;

        if (active && (cycle_q != '1)) begin
            cycle_d = cycle_q + CNT_W'(1);
        end

        if (commit) begin
            pc_d = next_pc_i;
            if (instr_q != '1) begin
                instr_d = instr_q + CNT_W'(1);
            end
            bp_hit_d = bp_hit_q | bp_match;
        end

        case (state_q)
            ST_IDLE: begin
                if (step_i) begin
                    state_d  = ST_STEP;
                    bp_hit_d = '0;
                end else if (run_i) begin
                    state_d  = ST_RUN;
                    bp_hit_d = '0;
                end
            end
            ST_RUN: begin
                if (fault) begin
                    state_d = ST_STOP;
                    stat_d  = stat_i;
                end else if ((bp_match != '0) || halt_req_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (fault) begin
                    state_d = ST_STOP;
                    stat_d  = stat_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Reset takes effect immediately; an in-flight instruction is simply dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            stat_q   <= STAT_AOK;
            bp_hit_q <= '0;
            cycle_q  <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            stat_q   <= stat_d;
            bp_hit_q <= bp_hit_d;
            cycle_q  <= cycle_d;
            instr_q  <= instr_d;
        end
    end

    assign pc_o        = pc_q;
    assign commit_o    = commit;
    assign state_o     = state_q;
    assign stat_o      = stat_q;
    assign bp_hit_o    = bp_hit_q;
    assign cycle_cnt_o = cycle_q;
    assign instr_cnt_o = instr_q;
endmodule

// File: tb/tb_y86_pc_sequencer.sv
// Bench for y86_pc_sequencer: two instances (RESET_PC=0x100/CNT_W=32 and RESET_PC=0/CNT_W=4)
// share control inputs; a behavioural model of each is checked every cycle, plus literal checkpoints.
module tb_y86_pc_sequencer;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   a_npc = 64'h0;
    logic [63:0]   b_npc = 64'h0;
    logic [3:0]    stat_r = 4'd1;
    logic          run_r = 1'b0;
    logic          step_r = 1'b0;
    logic          halt_r = 1'b0;
    logic [127:0]  bp_addr = '0;
    logic [1:0]    bp_en = 2'b00;

    logic [63:0]   a_pc, b_pc;
    logic          a_commit, b_commit;
    logic [1:0]    a_state, b_state, a_hit, b_hit;
    logic [3:0]    a_stat, b_stat;
    logic [31:0]   a_cyc, a_ins;
    logic [3:0]    b_cyc, b_ins;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    y86_pc_sequencer #(.ADDR_W(64), .RESET_PC(64'h100), .CNT_W(32), .NUM_BP(2)) u_a (
        .clk_i(clk), .rst_i(rst_n), .next_pc_i(a_npc), .stat_i(stat_r),
        .run_i(run_r), .step_i(step_r), .halt_req_i(halt_r),
        .bp_addr_i(bp_addr), .bp_en_i(bp_en),
        .pc_o(a_pc), .commit_o(a_commit), .state_o(a_state), .stat_o(a_stat),
        .bp_hit_o(a_hit), .cycle_cnt_o(a_cyc), .instr_cnt_o(a_ins));

    y86_pc_sequencer #(.ADDR_W(64), .RESET_PC(64'h0), .CNT_W(4), .NUM_BP(2)) u_b (
        .clk_i(clk), .rst_i(rst_n), .next_pc_i(b_npc), .stat_i(stat_r),
        .run_i(run_r), .step_i(step_r), .halt_req_i(halt_r),
        .bp_addr_i(bp_addr), .bp_en_i(bp_en),
        .pc_o(b_pc), .commit_o(b_commit), .state_o(b_state), .stat_o(b_stat),
        .bp_hit_o(b_hit), .cycle_cnt_o(b_cyc), .instr_cnt_o(b_ins));

    // Model state: st uses 0=IDLE 1=RUN 2=STEP 3=STOP as seen on state_o.
    typedef struct packed {
        logic [63:0] pc;
        logic [1:0]  st;
        logic [3:0]  stat;
        logic [1:0]  hit;
        logic [31:0] cyc;
        logic [31:0] ins;
    } mdl_t;

    mdl_t ma = '{pc: 64'h100, st: 2'd0, stat: 4'd1, hit: 2'b00, cyc: 32'd0, ins: 32'd0};
    mdl_t mb = '{pc: 64'h0,   st: 2'd0, stat: 4'd1, hit: 2'b00, cyc: 32'd0, ins: 32'd0};

    function automatic mdl_t mreset(input logic [63:0] rpc);
        mdl_t r;
        r.pc = rpc; r.st = 2'd0; r.stat = 4'd1; r.hit = 2'b00; r.cyc = 32'd0; r.ins = 32'd0;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic [63:0] npc, input logic [31:0] cmax);
        mdl_t r;
        logic [1:0] hits;
        r = m;
        hits = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (bp_en[k] && (npc == bp_addr[k*64 +: 64])) hits[k] = 1'b1;
        end
        if (m.st == 2'd0) begin
            if (step_r) begin
                r.st = 2'd2; r.hit = 2'b00;
            end else if (run_r) begin
                r.st = 2'd1; r.hit = 2'b00;
            end
        end else if (m.st == 2'd1 || m.st == 2'd2) begin
            if (m.cyc < cmax) r.cyc = m.cyc + 32'd1;
            if (stat_r != 4'd1) begin
                r.stat = stat_r;
                r.st = 2'd3;
            end else begin
                r.pc = npc;
                if (m.ins < cmax) r.ins = m.ins + 32'd1;
                r.hit = m.hit | hits;
                if (m.st == 2'd2 || hits != 2'b00 || halt_r) r.st = 2'd0;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset(64'h100);
            mb <= mreset(64'h0);
        end else begin
            ma <= mstep(ma, a_npc, 32'hFFFF_FFFF);
            mb <= mstep(mb, b_npc, 32'd15);
        end
    end

    // next_pc from updatePC is modelled as "pc + 10" of each core.
    always @(posedge clk) begin
        #1;
        a_npc = ma.pc + 64'd10;
        b_npc = mb.pc + 64'd10;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a.pc", a_pc, ma.pc);
        chk("a.state", 64'(a_state), 64'(ma.st));
        chk("a.stat", 64'(a_stat), 64'(ma.stat));
        chk("a.hit", 64'(a_hit), 64'(ma.hit));
        chk("a.cyc", 64'(a_cyc), 64'(ma.cyc));
        chk("a.ins", 64'(a_ins), 64'(ma.ins));
        chk("a.commit", 64'(a_commit), 64'((ma.st == 2'd1 || ma.st == 2'd2) && stat_r == 4'd1));
        chk("b.pc", b_pc, mb.pc);
        chk("b.state", 64'(b_state), 64'(mb.st));
        chk("b.stat", 64'(b_stat), 64'(mb.stat));
        chk("b.hit", 64'(b_hit), 64'(mb.hit));
        chk("b.cyc", 64'(b_cyc), 64'(mb.cyc));
        chk("b.ins", 64'(b_ins), 64'(mb.ins));
        chk("b.commit", 64'(b_commit), 64'((mb.st == 2'd1 || mb.st == 2'd2) && stat_r == 4'd1));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset and idle hold
        repeat (2) tick();
        #1 rst_n = 1'b1;
        tick();
        chk("t1.pc", a_pc, 64'h100);
        chk("t1.state", 64'(a_state), 64'd0);
        chk("t1.stat", 64'(a_stat), 64'd1);
        chk("t1.cyc", 64'(a_cyc), 64'd0);
        chk("t1.ins", 64'(a_ins), 64'd0);
        repeat (10) tick();
        chk("t1.hold_pc", a_pc, 64'h100);

        // Run five commits then HLT
        run_r = 1'b1;
        tick();
        run_r = 1'b0;
        repeat (5) tick();
        stat_r = 4'd2;
        tick();
        chk("t2.pc", a_pc, 64'h132);
        chk("t2.stat", 64'(a_stat), 64'd2);
        chk("t2.state", 64'(a_state), 64'd3);
        chk("t2.ins", 64'(a_ins), 64'd5);
        chk("t2.cyc", 64'(a_cyc), 64'd6);
        stat_r = 4'd1;
        run_r = 1'b1; step_r = 1'b1;
        repeat (2) tick();
        run_r = 1'b0; step_r = 1'b0;
        tick();
        chk("t2.stop_pc", a_pc, 64'h132);
        chk("t2.stop_state", 64'(a_state), 64'd3);

        // Breakpoint at 0x28 in slot 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bp_addr = {64'h28, 64'hFFFF_0000};
        bp_en = 2'b10;
        tick();
        run_r = 1'b1;
        tick();
        run_r = 1'b0;
        repeat (4) tick();
        chk("t3.state", 64'(b_state), 64'd0);
        chk("t3.pc", b_pc, 64'h28);
        chk("t3.hit", 64'(b_hit), 64'b10);
        chk("t3.ins", 64'(b_ins), 64'd4);
        step_r = 1'b1;
        tick();
        step_r = 1'b0;
        chk("t3.hit_clr", 64'(b_hit), 64'd0);
        tick();
        chk("t3.step_pc", b_pc, 64'h32);
        chk("t3.step_state", 64'(b_state), 64'd0);

        // step and run together: one commit
        step_r = 1'b1; run_r = 1'b1;
        tick();
        step_r = 1'b0; run_r = 1'b0;
        repeat (3) tick();
        chk("t4.ins", 64'(b_ins), 64'd6);
        chk("t4.pc", b_pc, 64'h3C);
        chk("t4.state", 64'(b_state), 64'd0);

        // Counter saturation at CNT_W=4
        bp_en = 2'b00;
        run_r = 1'b1;
        tick();
        run_r = 1'b0;
        repeat (20) tick();
        halt_r = 1'b1;
        tick();
        halt_r = 1'b0;
        tick();
        chk("t5.ins_sat", 64'(b_ins), 64'd15);
        chk("t5.cyc_sat", 64'(b_cyc), 64'd15);
        chk("t5.state", 64'(b_state), 64'd0);

        // Asynchronous reset mid-RUN
        run_r = 1'b1;
        tick();
        run_r = 1'b0;
        repeat (2) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("t6.pc", b_pc, 64'h0);
        chk("t6.state", 64'(b_state), 64'd0);
        chk("t6.stat", 64'(b_stat), 64'd1);
        chk("t6.ins", 64'(b_ins), 64'd0);
        chk("t6.cyc", 64'(b_cyc), 64'd0);
        chk("t6.a_pc", a_pc, 64'h100);
        #2 rst_n = 1'b1;
        repeat (5) tick();
        chk("t6.idle", 64'(b_state), 64'd0);
        chk("t6.idle_pc", b_pc, 64'h0);

        // Fault and breakpoint on the same edge: fault wins
        bp_en = 2'b10;
        run_r = 1'b1;
        tick();
        run_r = 1'b0;
        repeat (3) tick();
        chk("t7.pre_pc", b_pc, 64'h1E);
        stat_r = 4'd3;
        tick();
        chk("t7.state", 64'(b_state), 64'd3);
        chk("t7.pc", b_pc, 64'h1E);
        chk("t7.hit", 64'(b_hit), 64'd0);
        chk("t7.stat", 64'(b_stat), 64'd3);
        stat_r = 4'd1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
